// File: rtl/sbus_pattern_target.sv
// Simple-bus target that answers reads from an address echo, a sector RAM buffer,
// an address XOR pattern or a constant, with programmable wait states and saturating op counters.
module sbus_pattern_target #(
    parameter int unsigned ADDR_WIDTH  = 41,
    parameter int unsigned BUF_LOG2    = 9,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_start_op,
    input  logic                  bus_rw,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [7:0]            bus_data_in,
    input  logic [1:0]            mode,
    output logic                  bus_ready,
    output logic [7:0]            bus_data_out,
    output logic                  bus_data_oe,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  protocol_err
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned EXT_W     = (ADDR_WIDTH > 41) ? ADDR_WIDTH : 41;
    localparam int unsigned BUF_DEPTH = 1 << BUF_LOG2;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [1:0]            mode_q, mode_d;
    logic                  ready_q, ready_d;
    logic [7:0]            dout_q, dout_d;
    logic                  oe_q, oe_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic                  perr_q, perr_d;

    logic                  ram_we_c;
    logic                  ram_re_c;
    logic [BUF_LOG2-1:0]   ram_addr_c;
    logic [7:0]            ram_rdata_q;
    logic [7:0]            mem [BUF_DEPTH];

    logic [EXT_W-1:0]      addr_ext_c;
    logic [7:0]            result_c;

    // Read data for the latched operation; lanes past the address width read as zero.
    always_comb begin
        addr_ext_c = EXT_W'(addr_q);
        result_c   = 8'h00;
        case (mode_q)
            2'd0: begin
                case (addr_q[1:0])
                    2'd0:    result_c = addr_ext_c[16:9];
                    2'd1:    result_c = addr_ext_c[24:17];
                    2'd2:    result_c = addr_ext_c[32:25];
                    default: result_c = addr_ext_c[40:33];
                endcase
            end
            2'd1:    result_c = ram_rdata_q;
            2'd2:    result_c = addr_q[7:0] ^ addr_q[16:9];
            default: result_c = 8'hA5;
        endcase
    end

    // Next-state logic: the RAM is read on the accept edge and written on the completion edge.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        mode_d     = mode_q;
        ready_d    = ready_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        perr_d     = perr_q;
        ram_we_c   = 1'b0;
        ram_re_c   = 1'b0;
        ram_addr_c = bus_address[BUF_LOG2-1:0];

        if (bus_start_op && !ready_q) begin
            perr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus_start_op) begin
                    state_d  = ST_WAIT;
                    wait_d   = CNT_W'(WAIT_STATES);
                    addr_d   = bus_address;
                    rw_d     = bus_rw;
                    wdata_d  = bus_data_in;
                    mode_d   = mode;
                    ready_d  = 1'b0;
                    oe_d     = 1'b0;
                    ram_re_c = 1'b1;
                end
            end
            ST_WAIT: begin
                ram_addr_c = addr_q[BUF_LOG2-1:0];
                if (wait_q == '0) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    if (rw_q) begin
                        dout_d = result_c;
                        oe_d   = 1'b1;
                        if (rd_cnt_q != CNT_MAX) begin
                            rd_cnt_d = rd_cnt_q + 16'd1;
                        end
                    end else begin
                        ram_we_c = (mode_q == 2'd1);
                        if (wr_cnt_q != CNT_MAX) begin
                            wr_cnt_d = wr_cnt_q + 16'd1;
                        end
                    end
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reset) begin
            ram_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= 8'h00;
            mode_q   <= 2'd0;
            ready_q  <= 1'b1;
            dout_q   <= 8'h00;
            oe_q     <= 1'b0;
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            mode_q   <= mode_d;
            ready_q  <= ready_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            perr_q   <= perr_d;
        end
    end

    // Single-port sector buffer; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem[ram_addr_c] <= wdata_q;
        end else if (ram_re_c) begin
            ram_rdata_q <= mem[ram_addr_c];
        end
    end

    assign bus_ready    = ready_q;
    assign bus_data_out = dout_q;
    assign bus_data_oe  = oe_q;
    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_sbus_pattern_target.sv
// Bench for sbus_pattern_target: two instances (0 and 3 wait states) checked every cycle
// against an operation-level model, plus directed literal expectations.
module tb_sbus_pattern_target;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        start [2];
    logic        rw    [2];
    logic [40:0] addr  [2];
    logic [7:0]  din   [2];
    logic [1:0]  md    [2];
    logic        rdy   [2];
    logic [7:0]  dout  [2];
    logic        oe    [2];
    logic [15:0] rdc   [2];
    logic [15:0] wrc   [2];
    logic        perr  [2];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sbus_pattern_target #(.ADDR_WIDTH(41), .BUF_LOG2(9), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .bus_start_op(start[0]), .bus_rw(rw[0]),
        .bus_address(addr[0]), .bus_data_in(din[0]), .mode(md[0]),
        .bus_ready(rdy[0]), .bus_data_out(dout[0]), .bus_data_oe(oe[0]),
        .rd_count(rdc[0]), .wr_count(wrc[0]), .protocol_err(perr[0])
    );

    sbus_pattern_target #(.ADDR_WIDTH(41), .BUF_LOG2(9), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset(rst[1]), .bus_start_op(start[1]), .bus_rw(rw[1]),
        .bus_address(addr[1]), .bus_data_in(din[1]), .mode(md[1]),
        .bus_ready(rdy[1]), .bus_data_out(dout[1]), .bus_data_oe(oe[1]),
        .rd_count(rdc[1]), .wr_count(wrc[1]), .protocol_err(perr[1])
    );

    task automatic check(input string name, input int i, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, i, got, exp);
        end
    endtask

    // Operation-level model: an op is busy for WS+1 cycles, then completes.
    function automatic int ws(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    logic [7:0]  mbuf [int];
    int          busy   [2];
    logic        p_rw   [2];
    logic [40:0] p_addr [2];
    logic [7:0]  p_din  [2];
    logic [1:0]  p_mode [2];
    logic        e_rdy  [2];
    logic        e_oe   [2];
    logic        e_dk   [2];
    logic [7:0]  e_dout [2];
    int          e_rd   [2];
    int          e_wr   [2];
    logic        e_perr [2];

    function automatic int key(input int i, input logic [40:0] a);
        return i * 1024 + int'(a[8:0]);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                busy[i] = 0; e_rdy[i] = 1'b1; e_oe[i] = 1'b0; e_dk[i] = 1'b1;
                e_dout[i] = 8'h00; e_rd[i] = 0; e_wr[i] = 0; e_perr[i] = 1'b0;
            end else if (busy[i] > 0) begin
                if (start[i]) e_perr[i] = 1'b1;
                busy[i]--;
                if (busy[i] == 0) begin
                    longint unsigned a;
                    a = 64'(p_addr[i]);
                    e_rdy[i] = 1'b1;
                    if (p_rw[i]) begin
                        e_oe[i] = 1'b1;
                        e_dk[i] = 1'b1;
                        case (p_mode[i])
                            2'd0: e_dout[i] = 8'((a >> (9 + 8 * (a & 3))) & 64'hFF);
                            2'd1: begin
                                if (mbuf.exists(key(i, p_addr[i]))) e_dout[i] = mbuf[key(i, p_addr[i])];
                                else e_dk[i] = 1'b0;
                            end
                            2'd2: e_dout[i] = 8'((a & 64'hFF) ^ ((a >> 9) & 64'hFF));
                            default: e_dout[i] = 8'hA5;
                        endcase
                        e_rd[i] = (e_rd[i] < 65535) ? e_rd[i] + 1 : 65535;
                    end else begin
                        if (p_mode[i] == 2'd1) mbuf[key(i, p_addr[i])] = p_din[i];
                        e_wr[i] = (e_wr[i] < 65535) ? e_wr[i] + 1 : 65535;
                    end
                end
            end else if (start[i]) begin
                busy[i] = ws(i) + 1;
                e_rdy[i] = 1'b0; e_oe[i] = 1'b0;
                p_rw[i] = rw[i]; p_addr[i] = addr[i]; p_din[i] = din[i]; p_mode[i] = md[i];
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("ready", i, longint'(rdy[i]), longint'(e_rdy[i]));
                check("oe", i, longint'(oe[i]), longint'(e_oe[i]));
                check("rd_count", i, longint'(rdc[i]), longint'(e_rd[i]));
                check("wr_count", i, longint'(wrc[i]), longint'(e_wr[i]));
                check("protocol_err", i, longint'(perr[i]), longint'(e_perr[i]));
                if (e_oe[i] && e_dk[i]) check("data_out", i, longint'(dout[i]), longint'(e_dout[i]));
            end
        end
    end

    // Issue one op at the current negedge; returns at the negedge where ready is back.
    task automatic op(input int i, input logic r, input logic [40:0] a, input logic [7:0] d,
                      input logic [1:0] m, output int low);
        start[i] = 1'b1; rw[i] = r; addr[i] = a; din[i] = d; md[i] = m;
        @(negedge clk);
        start[i] = 1'b0; addr[i] = ~a; md[i] = ~m; din[i] = ~d;
        low = 0;
        while (rdy[i] !== 1'b1 && low < 40) begin
            low++;
            @(negedge clk);
        end
        if (rdy[i] !== 1'b1) check("ready_timeout", i, longint'(rdy[i]), 1);
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (rdy[i] !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (rdy[i] !== 1'b1) check("ready_timeout", i, longint'(rdy[i]), 1);
    endtask

    task automatic pulse_reset(input int i);
        rst[i] = 1'b1;
        @(negedge clk);
        rst[i] = 1'b0;
    endtask

    int lw;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; rw[i] = 1'b0;
            addr[i] = '0; din[i] = 8'h00; md[i] = 2'd0;
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", i, longint'(rdy[i]), 1);
            check("rst_dout", i, longint'(dout[i]), 0);
            check("rst_oe", i, longint'(oe[i]), 0);
            check("rst_rdc", i, longint'(rdc[i]), 0);
            check("rst_wrc", i, longint'(wrc[i]), 0);
            check("rst_perr", i, longint'(perr[i]), 0);
            rst[i] = 1'b0;
        end
        @(negedge clk);

        // Address echo, zero wait states.
        op(0, 1'b1, 41'h5A << 9, 8'h00, 2'd0, lw);
        check("m0_low_cycles", 0, lw, 1);
        check("m0_dout", 0, longint'(dout[0]), 'h5A);
        check("m0_oe", 0, longint'(oe[0]), 1);
        check("m0_rdc", 0, longint'(rdc[0]), 1);

        // Buffer: seed addr 0, reset, then write/read 0x1FF back-to-back.
        op(0, 1'b0, 41'h000, 8'h5C, 2'd1, lw);
        pulse_reset(0);
        check("rst2_rdc", 0, longint'(rdc[0]), 0);
        op(0, 1'b0, 41'h1FF, 8'h3C, 2'd1, lw);
        check("m1_wr_oe", 0, longint'(oe[0]), 0);
        op(0, 1'b1, 41'h1FF, 8'h00, 2'd1, lw);
        check("m1_dout", 0, longint'(dout[0]), 'h3C);
        check("m1_wrc", 0, longint'(wrc[0]), 1);
        check("m1_rdc", 0, longint'(rdc[0]), 1);
        op(0, 1'b1, 41'h000, 8'h00, 2'd1, lw);
        check("m1_addr0_kept", 0, longint'(dout[0]), 'h5C);

        // Writes in non-buffer modes are discarded but counted.
        op(0, 1'b0, 41'h1FF, 8'hEE, 2'd0, lw);
        op(0, 1'b0, 41'h1FF, 8'hDD, 2'd2, lw);
        op(0, 1'b0, 41'h1FF, 8'hCC, 2'd3, lw);
        op(0, 1'b1, 41'h1FF, 8'h00, 2'd1, lw);
        check("discard_dout", 0, longint'(dout[0]), 'h3C);
        check("discard_wrc", 0, longint'(wrc[0]), 4);

        // Echo lanes k=1..3.
        op(0, 1'b1, (41'h96 << 17) | 41'd1, 8'h00, 2'd0, lw);
        check("m0_k1", 0, longint'(dout[0]), 'h96);
        op(0, 1'b1, (41'h4B << 25) | 41'd2, 8'h00, 2'd0, lw);
        check("m0_k2", 0, longint'(dout[0]), 'h4B);
        op(0, 1'b1, (41'hC3 << 33) | 41'd3, 8'h00, 2'd0, lw);
        check("m0_k3", 0, longint'(dout[0]), 'hC3);

        // Three wait states, XOR pattern.
        op(1, 1'b1, 41'h234, 8'h00, 2'd2, lw);
        check("m2_low_cycles", 1, lw, 4);
        check("m2_dout", 1, longint'(dout[1]), 'h35);

        // Start pulsed during WAIT.
        start[1] = 1'b1; rw[1] = 1'b1; md[1] = 2'd3; addr[1] = '0;
        @(negedge clk);
        start[1] = 1'b0;
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_ready(1);
        check("perr_set", 1, longint'(perr[1]), 1);
        check("perr_rdc", 1, longint'(rdc[1]), 2);
        check("perr_dout", 1, longint'(dout[1]), 'hA5);
        op(1, 1'b1, 41'h0, 8'h00, 2'd3, lw);
        check("perr_sticky", 1, longint'(perr[1]), 1);
        check("perr_rdc2", 1, longint'(rdc[1]), 3);

        // Reset mid-WAIT aborts a buffer write.
        pulse_reset(1);
        op(1, 1'b0, 41'h005, 8'h22, 2'd1, lw);
        start[1] = 1'b1; rw[1] = 1'b0; md[1] = 2'd1; addr[1] = 41'h005; din[1] = 8'h77;
        @(negedge clk);
        start[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        check("abort_ready", 1, longint'(rdy[1]), 1);
        check("abort_wrc", 1, longint'(wrc[1]), 0);
        check("abort_rdc", 1, longint'(rdc[1]), 0);
        rst[1] = 1'b0;
        @(negedge clk);
        op(1, 1'b1, 41'h005, 8'h00, 2'd1, lw);
        check("abort_buf", 1, longint'(dout[1]), 'h22);

        // Read counter saturation.
        pulse_reset(0);
        rw[0] = 1'b1; md[0] = 2'd3; addr[0] = '0;
        for (int n = 0; n < 65538; n++) begin
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
            @(negedge clk);
        end
        check("sat_rdc", 0, longint'(rdc[0]), 'hFFFF);
        check("sat_dout", 0, longint'(dout[0]), 'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
